// File: rtl/rhs_spi_slave.sv
// rtl/rhs_spi_slave.sv - SPI responder (CPOL=0, MSB first) for the RHS 32-bit command link
module rhs_spi_slave #(
    parameter int   SYNC_STAGES = 2,
    parameter int   WORD_BITS   = 32,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        frame_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_END   = 2'd2
    } state_t;

    // Full-frame bit count; the 6-bit counter saturates here.
    localparam logic [5:0] LP_FULL = 6'(WORD_BITS);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    state_t      r_state;
    logic [5:0]  r_bit_cnt;
    logic [31:0] r_rx_shift;
    logic [31:0] r_tx_shift;
    logic        r_overrun;
    logic        r_cs_pend;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;

    // Bring SCLK/CS/MOSI into the clk domain; MOSI uses the same depth as SCLK so a
    // synced rising edge always sees the data bit the master set up before it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    // Frame FSM: capture response at CS fall, shift both directions, judge the frame at CS rise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_overrun   <= 1'b0;
            r_cs_pend   <= 1'b0;
            MISO        <= IDLE_MISO;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    MISO <= IDLE_MISO;
                    busy <= 1'b0;
                    // A CS fall seen during END is remembered and started here.
                    if (w_cs_fall || r_cs_pend) begin
                        r_tx_shift <= tx_data;
                        MISO       <= tx_data[31];
                        r_bit_cnt  <= '0;
                        r_overrun  <= 1'b0;
                        r_cs_pend  <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_sclk_rise) begin
                        if (r_bit_cnt < LP_FULL) begin
                            r_rx_shift <= {r_rx_shift[30:0], w_mosi_s};
                            r_bit_cnt  <= r_bit_cnt + 6'd1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                    if (w_sclk_fall) begin
                        if (r_bit_cnt < LP_FULL) begin
                            r_tx_shift <= r_tx_shift << 1;
                            MISO       <= r_tx_shift[30];
                        end else begin
                            MISO <= IDLE_MISO;
                        end
                    end
                    // A same-cycle SCLK rise is counted above before the frame closes.
                    if (w_cs_rise) begin
                        busy    <= 1'b0;
                        r_state <= ST_END;
                    end
                end
                ST_END: begin
                    if (r_bit_cnt == LP_FULL && !r_overrun) begin
                        rx_data  <= r_rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                    MISO      <= IDLE_MISO;
                    busy      <= 1'b0;
                    r_cs_pend <= w_cs_fall;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rhs_spi_slave.md
Name: rhs_spi_slave

Overview:
- SPI responder for the RHS 32-bit command link; the slave end of the link our SPI master drives.
- Oversamples SCLK/CS/MOSI in the system clock domain, shifts in one 32-bit command per CS-low frame, and shifts out a 32-bit response word on MISO.
- Used as a chip model for master loopback and for board-level bridge tests. Protocol is fixed:
  - CPOL=0.
  - MOSI sampled on SCLK rise; MISO changes on SCLK fall.
  - MSB first.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCLK, CS and MOSI (legal 2..3).
- WORD_BITS, 32, bits per frame.
- IDLE_MISO, 0, MISO level while CS high or after the last bit.

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- rstn  input  1  reset, asynchronous assert, active-low.
- SCLK  input  1  serial clock from master, asynchronous to clk.
- CS  input  1  chip select from master, active-low, asynchronous.
- MOSI  input  1  serial data from master.
- MISO  output  1  serial data to master.
- tx_data  input  32  response word; captured at frame start.
- rx_data  output  32  last complete command word received.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- frame_error  output  1  one-clk pulse when a frame ends with a bad bit count.
- busy  output  1  high while a frame is active (synchronized CS low).

Behaviour:
- Reset (rstn low, asynchronous):
  - State IDLE; bit counter 0; shift registers 0; synchronizers cleared (CS sync chain cleared to 1).
  - Outputs: MISO=IDLE_MISO, rx_data=0, rx_valid=0, frame_error=0, busy=0.
  - Reset release is synchronous to clk.
- Input synchronization:
  - SCLK, CS and MOSI each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - sclk_rise, sclk_fall, cs_fall and cs_rise are single-cycle strobes.
- States: IDLE, SHIFT, END.
- IDLE:
  - MISO=IDLE_MISO, busy=0. SCLK edges are ignored.
  - On cs_fall: tx_shift<=tx_data, MISO<=tx_data[31], bit_cnt<=0, go to SHIFT. busy=1 from the next cycle.
- SHIFT:
  - On sclk_rise: rx_shift<={rx_shift[30:0], MOSI_sync}; bit_cnt<=bit_cnt+1.
  - On sclk_fall, if bit_cnt<WORD_BITS: tx_shift shifts left and MISO<=the new tx_shift[31]. The first fall therefore presents bit 30.
  - When bit_cnt reaches WORD_BITS: MISO<=IDLE_MISO on the next sclk_fall; further sclk_rise edges set an overrun flag and do not shift.
  - On cs_rise, go to END.
- END (one cycle):
  - If bit_cnt==WORD_BITS and no overrun: rx_data<=rx_shift, rx_valid=1 for one cycle.
  - Otherwise: frame_error=1 for one cycle and rx_data holds its old value.
  - Then go to IDLE; MISO=IDLE_MISO, busy=0.
- Latency: rx_valid is asserted SYNC_STAGES+2 clk cycles after the raw CS rising edge.
- Simultaneous events:
  - sclk_rise and cs_rise in the same cycle: the rise is counted first, then CS is handled.
  - cs_fall in END: taken on the following IDLE cycle. CS high for 1 synced cycle is the minimum separation that is not lost.
- Zero-length frame (CS pulse with no SCLK) gives frame_error=1.
- tx_data changes mid-frame have no effect on the current frame.
- Counter width: 6 bits, saturating at WORD_BITS.
- Reset mid-frame: returns to IDLE immediately; no rx_valid or frame_error for the aborted frame.

Test Plan:
- Basic frame: tx_data=0xA5A5_0F0F, master sends 0x1234_5678 (SCLK=clk/8) -> rx_data=0x12345678, rx_valid single pulse; master reads 0xA5A50F0F; frame_error never set.
- Back-to-back: three frames 0xFFFF_FFFF, 0x0000_0000, 0x8000_0001 with CS high for 4 clk between them -> three rx_valid pulses, each with the matching rx_data.
- Short frame: CS low, 16 SCLK cycles, CS high -> frame_error pulse; rx_data keeps its previous value (0x80000001).
- Overrun frame: 33 SCLK cycles -> frame_error pulse, no rx_valid; MISO=IDLE_MISO after bit 0.
- Reset mid-frame: rstn low after 10 bits, then a full frame of 0xDEAD_BEEF -> the first frame produces no pulses; the second gives rx_data=0xDEADBEEF.
- Idle noise: SCLK toggling with CS high -> busy=0, MISO=0, no pulses, rx_data unchanged.
